fifo_uart_drain: RTL and testbench
==================================

# fifo_uart_drain

Read-side sequencer for the 8-bit AD sample FIFO. It drains bytes from the FIFO one at a time and hands each byte to the UART transmitter over a start/busy handshake. It never reads an empty FIFO and tracks frame boundaries: a frame ends at the 0x0D,0x0A terminator that the polling controller appends after each 32-channel scan. It sits between the AD FIFO (`rdreq`/`q`/`empty`) and the UART TX core, and replaces the free-running `rdreq` tie-off.

## Interface
- `ACK_TIMEOUT`, default 16'd1000. Maximum cycles to wait for `tx_busy` to rise after `tx_start`.
- `clk` in 1: 50 MHz system clock.
- `reset_n` in 1: asynchronous reset, active-low. All state clears immediately on assertion.
- `enable` in 1: drain enable, level, active-high.
- `empty` in 1: FIFO empty flag.
- `q` in 8: FIFO read data. Normal (non-show-ahead) mode, so `q` is valid the cycle after `rdreq`.
- `rdreq` out 1: FIFO read request, one cycle per byte.
- `tx_busy` in 1: UART busy. High while a byte is shifting out.
- `tx_start` out 1: one-cycle pulse. `tx_data` is stable during this cycle and afterwards.
- `tx_data` out 8: byte for the UART. Held until the next byte is latched.
- `frame_done` out 1: one-cycle pulse when a 0x0D,0x0A pair has completed transmission.
- `frame_cnt` out 16: number of frames sent. Wraps 0xFFFF→0.
- `byte_cnt` out 16: bytes sent since the last frame end. Saturates at 0xFFFF.
- `err_timeout` out 1: sticky flag, set on an ACK timeout. Cleared only by reset.

## Operation
- States: IDLE, RD, LATCH, START, WAIT_ACK, WAIT_DONE.
- IDLE: if `enable`=1 and `empty`=0, go to RD. Otherwise stay.
- RD: `rdreq`=1 for exactly this cycle. Unconditionally go to LATCH.
- LATCH: `tx_data`<=`q`. Go to START.
- START: `tx_start`=1. Clear the ack counter. Go to WAIT_ACK.
- WAIT_ACK:
  - If `tx_busy`=1, go to WAIT_DONE.
  - Else, if the ack counter ≥ `ACK_TIMEOUT`−1, set `err_timeout`=1, drop the byte (no counter update), and go to IDLE.
  - Else increment the ack counter.
- WAIT_DONE: when `tx_busy`=0, the byte is complete. Run the frame logic and go to IDLE.
- `rdreq` and `tx_start` are Moore outputs decoded from the state register only.
- Frame logic runs on byte completion only:
  - Register `prev_cr` is set iff the completed byte is 0x0D.
  - If the completed byte is 0x0A and `prev_cr`=1: pulse `frame_done`, `frame_cnt`+1, `byte_cnt`<=0.
  - Otherwise `byte_cnt`+1, saturating.
  - A lone 0x0A, or 0x0D followed by any other byte, is an ordinary data byte.
- `enable` is sampled in IDLE only. Deasserting it mid-byte finishes the current byte and then parks in IDLE.
- A timed-out byte does not modify `prev_cr`.
- Reset values: state IDLE, `rdreq`=0, `tx_start`=0, `tx_data`=0x00, `frame_done`=0, `frame_cnt`=0, `byte_cnt`=0, `err_timeout`=0, `prev_cr`=0, ack counter=0.

## Timing
- Cycle N: IDLE sees `enable`=1 and `empty`=0. RD is at N+1 (`rdreq`=1), LATCH at N+2, and `tx_data` is valid from N+3.
- `tx_start` is high at N+3 only.
- Minimum per byte is 6 cycles (IDLE, RD, LATCH, START, 1×WAIT_ACK, 1×WAIT_DONE), with `tx_busy` rising at N+4 and falling at N+5.
- Throughput is bounded by the UART, about 10 bit periods per byte.
- `rdreq` is never high when `empty` was 1 in the preceding IDLE cycle. Because each read is a single byte, no more than one read is ever in flight, so underflow is impossible.
- `frame_done`, and the `frame_cnt`/`byte_cnt` updates, are registered in the cycle WAIT_DONE→IDLE. The pulse is visible in the first IDLE cycle.
- Timeout: with `tx_busy` stuck at 0, `err_timeout` rises exactly `ACK_TIMEOUT` cycles after the START cycle, and the FSM is in IDLE the next cycle.
- `reset_n` low mid-byte: all outputs take their reset values asynchronously. A byte already popped from the FIFO is lost. This is accepted, because the FIFO is reset by the same `reset_n`.

## Test plan
1. **Single byte.** Push 0x5A, `enable`=1, UART model busy for 3 cycles. Expect one `rdreq`, then `tx_start` with `tx_data`=0x5A at N+3, `byte_cnt`=1, no `frame_done`.
2. **Full frame.** Push 32 samples followed by 0xCC, 0x0D, 0x0A. Expect 35 `tx_start` pulses in FIFO order and one `frame_done` after the 0x0A completes. Then `frame_cnt`=1 and `byte_cnt`=0.
3. **Empty and enable gating.**
   - FIFO empty with `enable`=1: `rdreq` stays 0 for 100 cycles.
   - Drop `enable` during WAIT_DONE of byte 1 of 3: byte 1 completes, bytes 2–3 remain in the FIFO (`empty`=0).
4. **Terminator edge cases.** Send 0x0A, 0x0D, 0x41, 0x0D, 0x0D, 0x0A. Expect exactly one `frame_done`, after the last byte, and `byte_cnt`=0.
5. **Timeout.** With `ACK_TIMEOUT`=8, hold `tx_busy`=0. Expect `err_timeout`=1 eight cycles after `tx_start`, `byte_cnt` unchanged, and the next FIFO byte still sent normally. `err_timeout` stays set until `reset_n` pulses low.
6. **Reset mid-transfer.** Assert `reset_n`=0 during WAIT_ACK. Expect all outputs at their reset values within the same cycle, and IDLE after release.

Source files
------------

// File: rtl/fifo_uart_drain.sv
// Read-side sequencer: pops one byte at a time from the AD sample FIFO and hands
// it to the UART TX over a start/busy handshake, tracking CR/LF frame boundaries.
module fifo_uart_drain #(
    parameter logic [15:0] ACK_TIMEOUT = 16'd1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        empty,
    input  logic [7:0]  q,
    output logic        rdreq,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic [15:0] byte_cnt,
    output logic        err_timeout
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RD        = 3'd1,
        ST_LATCH     = 3'd2,
        ST_START     = 3'd3,
        ST_WAIT_ACK  = 3'd4,
        ST_WAIT_DONE = 3'd5
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [15:0] ack_cnt_r;
    logic [7:0]  tx_data_r;
    logic        prev_cr_r;
    logic        frame_done_r;
    logic [15:0] frame_cnt_r;
    logic [15:0] byte_cnt_r;
    logic        err_timeout_r;
    logic        ack_timeout_s;
    logic        byte_done_s;
    logic        frame_end_s;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            sat_inc16 = v;
        end else begin
            sat_inc16 = v + 16'd1;
        end
    endfunction

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode plus the byte-complete and ack-timeout strobes.
    always_comb begin
        state_s       = state_r;
        ack_timeout_s = 1'b0;
        byte_done_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enable && !empty) begin
                    state_s = ST_RD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RD:    state_s = ST_LATCH;
            ST_LATCH: state_s = ST_START;
            ST_START: state_s = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (tx_busy) begin
                    state_s = ST_WAIT_DONE;
                end else if (ack_cnt_r >= (ACK_TIMEOUT - 16'd1)) begin
                    ack_timeout_s = 1'b1;
                    state_s       = ST_IDLE;
                end else begin
                    state_s = ST_WAIT_ACK;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    byte_done_s = 1'b1;
                    state_s     = ST_IDLE;
                end else begin
                    state_s = ST_WAIT_DONE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // A frame ends only when LF completes right after a completed CR.
    assign frame_end_s = byte_done_s && (tx_data_r == 8'h0A) && prev_cr_r;

    // Ack counter: cleared in START, counts idle WAIT_ACK cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_cnt_r <= 16'd0;
        end else if (state_r == ST_START) begin
            ack_cnt_r <= 16'd0;
        end else if ((state_r == ST_WAIT_ACK) && !tx_busy && !ack_timeout_s) begin
            ack_cnt_r <= ack_cnt_r + 16'd1;
        end else begin
            ack_cnt_r <= ack_cnt_r;
        end
    end

    // Output byte latch; q is valid the cycle after rdreq.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_data_r <= 8'h00;
        end else if (state_r == ST_LATCH) begin
            tx_data_r <= q;
        end else begin
            tx_data_r <= tx_data_r;
        end
    end

    // Frame tracking; timed-out bytes never reach here, so prev_cr survives them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_cr_r    <= 1'b0;
            frame_done_r <= 1'b0;
            frame_cnt_r  <= 16'd0;
            byte_cnt_r   <= 16'd0;
        end else begin
            frame_done_r <= frame_end_s;
            if (byte_done_s) begin
                prev_cr_r <= (tx_data_r == 8'h0D);
            end else begin
                prev_cr_r <= prev_cr_r;
            end
            if (frame_end_s) begin
                frame_cnt_r <= frame_cnt_r + 16'd1;
                byte_cnt_r  <= 16'd0;
            end else if (byte_done_s) begin
                frame_cnt_r <= frame_cnt_r;
                byte_cnt_r  <= sat_inc16(byte_cnt_r);
            end else begin
                frame_cnt_r <= frame_cnt_r;
                byte_cnt_r  <= byte_cnt_r;
            end
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_timeout_r <= 1'b0;
        end else if (ack_timeout_s) begin
            err_timeout_r <= 1'b1;
        end else begin
            err_timeout_r <= err_timeout_r;
        end
    end

    assign rdreq       = (state_r == ST_RD);
    assign tx_start    = (state_r == ST_START);
    assign tx_data     = tx_data_r;
    assign frame_done  = frame_done_r;
    assign frame_cnt   = frame_cnt_r;
    assign byte_cnt    = byte_cnt_r;
    assign err_timeout = err_timeout_r;

endmodule

// File: tb/tb_fifo_uart_drain.sv
// Directed bench for fifo_uart_drain with a normal-mode FIFO model and a UART
// busy model; expected values are hand-computed constants.
module tb_fifo_uart_drain;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        empty;
    logic [7:0]  q = 8'h00;
    logic        rdreq;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic [15:0] byte_cnt;
    logic        err_timeout;

    int n_cmp = 0;
    int n_err = 0;

    fifo_uart_drain #(.ACK_TIMEOUT(16'd8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .empty      (empty),
        .q          (q),
        .rdreq      (rdreq),
        .tx_busy    (tx_busy),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .byte_cnt   (byte_cnt),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // FIFO model (normal mode: q updates on the edge that sees rdreq)
    logic [7:0] mem [0:255];
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] rd_ptr = 8'd0;
    assign empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (rdreq) begin
            q      <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 8'd1;
        end
    end

    // UART model: busy for busy_len cycles after tx_start; 0 means never acks
    int         busy_len = 3;
    logic [7:0] bcnt = 8'd0;
    assign tx_busy = (bcnt != 8'd0);

    always @(posedge clk) begin
        if (tx_start && busy_len > 0) begin
            bcnt <= 8'(busy_len);
        end else if (bcnt != 8'd0) begin
            bcnt <= bcnt - 8'd1;
        end
    end

    // Monitors
    int         rd_cnt = 0;
    int         start_cnt = 0;
    int         fd_cnt = 0;
    int         uf_cnt = 0;
    int         log_n = 0;
    logic [7:0] tx_log [0:255];

    always @(negedge clk) begin
        if (rdreq) rd_cnt <= rd_cnt + 1;
        if (rdreq && empty) uf_cnt <= uf_cnt + 1;
        if (frame_done) fd_cnt <= fd_cnt + 1;
        if (tx_start) begin
            start_cnt     <= start_cnt + 1;
            tx_log[log_n[7:0]] <= tx_data;
            log_n         <= log_n + 1;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [7:0]  data;
        logic        fd;
        logic [15:0] bc;
        logic [15:0] fc;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_ptr] = d;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic wait_start(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            if (tx_start) ok = 1'b1;
        end
    endtask

    // Send one byte through an idle DUT and check timing-exact results.
    task automatic run_vec(input vec_t v, input string nm);
        logic ok;
        push(v.data);
        wait_start(ok);
        chk({nm, "_start"}, 32'(ok), 32'd1);
        chk({nm, "_txdata"}, 32'(tx_data), 32'(v.data));
        repeat (5) tick();
        chk({nm, "_frame_done"}, 32'(frame_done), 32'(v.fd));
        chk({nm, "_byte_cnt"}, 32'(byte_cnt), 32'(v.bc));
        chk({nm, "_frame_cnt"}, 32'(frame_cnt), 32'(v.fc));
    endtask

    initial begin
        vec_t       tab [9];
        logic [7:0] exp2 [35];
        int         rd0, s0, f0, l0;
        logic       ok;

        tab[0] = '{8'h0A, 1'b0, 16'd1, 16'd1};
        tab[1] = '{8'h0D, 1'b0, 16'd2, 16'd1};
        tab[2] = '{8'h41, 1'b0, 16'd3, 16'd1};
        tab[3] = '{8'h0D, 1'b0, 16'd4, 16'd1};
        tab[4] = '{8'h0D, 1'b0, 16'd5, 16'd1};
        tab[5] = '{8'h0A, 1'b1, 16'd0, 16'd2};
        tab[6] = '{8'h0D, 1'b0, 16'd1, 16'd2};
        tab[7] = '{8'h0A, 1'b1, 16'd0, 16'd3};
        tab[8] = '{8'h0A, 1'b0, 16'd1, 16'd3};

        // Reset state
        repeat (3) tick();
        chk("rst_rdreq", 32'(rdreq), 32'd0);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_byte_cnt", 32'(byte_cnt), 32'd0);
        reset_n = 1'b1;
        tick();

        // Single byte with exact cycle timing
        enable = 1'b1;
        push(8'h5A);
        tick();
        chk("t1_rdreq_n1", 32'(rdreq), 32'd1);
        tick();
        chk("t1_rdreq_n2", 32'(rdreq), 32'd0);
        chk("t1_start_n2", 32'(tx_start), 32'd0);
        tick();
        chk("t1_start_n3", 32'(tx_start), 32'd1);
        chk("t1_txdata_n3", 32'(tx_data), 32'h5A);
        tick();
        chk("t1_start_n4", 32'(tx_start), 32'd0);
        repeat (4) tick();
        chk("t1_byte_cnt", 32'(byte_cnt), 32'd1);
        chk("t1_frame_done", 32'(frame_done), 32'd0);
        chk("t1_rd_count", 32'(rd_cnt), 32'd1);
        chk("t1_start_count", 32'(start_cnt), 32'd1);

        // Empty FIFO: no reads
        rd0 = rd_cnt;
        repeat (100) tick();
        chk("t3_empty_no_rdreq", 32'(rd_cnt - rd0), 32'd0);

        // Drop enable during WAIT_DONE of the first of three bytes
        rd0 = rd_cnt;
        s0  = start_cnt;
        push(8'h31);
        push(8'h32);
        push(8'h33);
        repeat (5) tick();
        enable = 1'b0;
        repeat (30) tick();
        chk("t3_gate_rd", 32'(rd_cnt - rd0), 32'd1);
        chk("t3_gate_start", 32'(start_cnt - s0), 32'd1);
        chk("t3_gate_empty", 32'(empty), 32'd0);
        chk("t3_gate_byte_cnt", 32'(byte_cnt), 32'd2);
        enable = 1'b1;
        repeat (40) tick();
        chk("t3_drain_rd", 32'(rd_cnt - rd0), 32'd3);
        chk("t3_drain_byte_cnt", 32'(byte_cnt), 32'd4);
        chk("t3_drain_empty", 32'(empty), 32'd1);

        // Full frame: 32 samples, 0xCC, CR, LF
        for (int i = 0; i < 32; i++) exp2[i] = 8'h10 + 8'(i);
        exp2[32] = 8'hCC;
        exp2[33] = 8'h0D;
        exp2[34] = 8'h0A;
        s0 = start_cnt;
        f0 = fd_cnt;
        l0 = log_n;
        for (int i = 0; i < 35; i++) push(exp2[i]);
        ok = 1'b0;
        for (int i = 0; i < 600 && !ok; i++) begin
            tick();
            if (fd_cnt != f0) ok = 1'b1;
        end
        chk("t2_frame_seen", 32'(ok), 32'd1);
        chk("t2_start_count", 32'(start_cnt - s0), 32'd35);
        chk("t2_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("t2_byte_cnt", 32'(byte_cnt), 32'd0);
        for (int i = 0; i < 35; i++) begin
            chk($sformatf("t2_order_%0d", i), 32'(tx_log[8'(l0 + i)]), 32'(exp2[i]));
        end
        repeat (10) tick();
        chk("t2_fd_pulses", 32'(fd_cnt - f0), 32'd1);

        // Terminator edge cases, table-driven
        for (int i = 0; i < 9; i++) begin
            run_vec(tab[i], $sformatf("t4_vec%0d", i));
        end

        // Timeout: CR completes, LF times out, next LF still closes the frame
        run_vec('{8'h0D, 1'b0, 16'd2, 16'd3}, "t5_cr");
        busy_len = 0;
        push(8'h0A);
        wait_start(ok);
        chk("t5_start", 32'(ok), 32'd1);
        repeat (8) tick();
        chk("t5_err_before", 32'(err_timeout), 32'd0);
        tick();
        chk("t5_err_set", 32'(err_timeout), 32'd1);
        chk("t5_byte_cnt_kept", 32'(byte_cnt), 32'd2);
        chk("t5_frame_cnt_kept", 32'(frame_cnt), 32'd3);
        busy_len = 3;
        run_vec('{8'h0A, 1'b1, 16'd0, 16'd4}, "t5_next");
        chk("t5_err_sticky", 32'(err_timeout), 32'd1);

        // Reset during WAIT_ACK
        busy_len = 0;
        push(8'h55);
        wait_start(ok);
        chk("t6_start", 32'(ok), 32'd1);
        tick();
        reset_n = 1'b0;
        #1;
        chk("t6_rdreq", 32'(rdreq), 32'd0);
        chk("t6_tx_start", 32'(tx_start), 32'd0);
        chk("t6_tx_data", 32'(tx_data), 32'd0);
        chk("t6_frame_done", 32'(frame_done), 32'd0);
        chk("t6_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("t6_byte_cnt", 32'(byte_cnt), 32'd0);
        chk("t6_err", 32'(err_timeout), 32'd0);
        tick();
        reset_n  = 1'b1;
        busy_len = 3;
        tick();
        run_vec('{8'h42, 1'b0, 16'd1, 16'd0}, "t6_after");

        chk("no_underflow", 32'(uf_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
